des_phase_align_ctrl: RTL and testbench



---
 rtl/des_phase_align_if.sv | 25 ++
 rtl/des_phase_align_ctrl.sv | 165 ++++++++++++++++
 tb/tb_des_phase_align_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_phase_align_if.sv
// Signal bundle between the phase-alignment controller, link firmware and the 72:288 deserializer.
// master = alignment controller view, slave = firmware/deserializer side view.
interface des_phase_align_if #(
  parameter int W = 9
);
  logic         enable;
  logic         relock;
  logic [W-1:0] train_pattern;
  logic [W-1:0] probe;
  logic         des_rst;
  logic [1:0]   des_phi_init;
  logic         locked;
  logic         align_fail;
  logic [2:0]   attempts;

  modport master (
    input  enable, relock, train_pattern, probe,
    output des_rst, des_phi_init, locked, align_fail, attempts
  );

  modport slave (
    output enable, relock, train_pattern, probe,
    input  des_rst, des_phi_init, locked, align_fail, attempts
  );
endinterface

// File: rtl/des_phase_align_ctrl.sv
// Word-alignment controller: sweeps the four deserializer phases, checks slot-0 against
// the training word every 4th cycle and reports lock or sweep exhaustion.
module des_phase_align_ctrl #(
  parameter int W          = 9,
  parameter int RST_CYC    = 2,
  parameter int SETTLE_CYC = 16,
  parameter int MATCH_N    = 8,
  parameter int MAX_SWEEPS = 2
) (
  input  logic              clk,
  input  logic              rst,
  des_phase_align_if.master bus
);

  localparam int TMAX    = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int MW      = (MATCH_N > 1) ? $clog2(MATCH_N) : 1;
  localparam int ATT_MAX = 4 * MAX_SWEEPS;
  localparam int AW      = $clog2(ATT_MAX + 1);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_N - 1);
  localparam logic [AW-1:0] ATT_LAST    = AW'(ATT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_LOCKED, S_FAIL
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tmr_reg, tmr_next;
  logic [1:0]    fc_reg, fc_next;
  logic [MW-1:0] mcnt_reg, mcnt_next;
  logic [1:0]    cand_reg, cand_next;
  logic [AW-1:0] att_reg, att_next;
  logic          des_rst_reg, des_rst_next;
  logic          locked_reg, locked_next;
  logic          align_fail_reg, align_fail_next;
  logic [2:0]    attempts_reg, attempts_next;

  logic [W-1:0]  diff;
  logic          match;

  assign diff  = bus.probe ^ bus.train_pattern;
  assign match = ~|diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      tmr_reg        <= '0;
      fc_reg         <= '0;
      mcnt_reg       <= '0;
      cand_reg       <= '0;
      att_reg        <= '0;
      des_rst_reg    <= 1'b1;
      locked_reg     <= 1'b0;
      align_fail_reg <= 1'b0;
      attempts_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      tmr_reg        <= tmr_next;
      fc_reg         <= fc_next;
      mcnt_reg       <= mcnt_next;
      cand_reg       <= cand_next;
      att_reg        <= att_next;
      des_rst_reg    <= des_rst_next;
      locked_reg     <= locked_next;
      align_fail_reg <= align_fail_next;
      attempts_reg   <= attempts_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    fc_next    = fc_reg;
    mcnt_next  = mcnt_reg;
    cand_next  = cand_reg;
    att_next   = att_reg;
    if (state_reg != S_IDLE && !bus.enable) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.enable) state_next = S_APPLY;
        end
        S_APPLY: begin
          if (tmr_reg == RST_LAST) begin
            state_next = S_SETTLE;
            tmr_next   = '0;
          end else begin
            tmr_next = tmr_reg + TW'(1);
          end
        end
        S_SETTLE: begin
          if (tmr_reg == SETTLE_LAST) begin
            state_next = S_CHECK;
            tmr_next   = '0;
            fc_next    = '0;
            mcnt_next  = '0;
          end else begin
            tmr_next = tmr_reg + TW'(1);
          end
        end
        S_CHECK: begin
          fc_next = fc_reg + 2'd1;
          // Only the last cycle of each 4-cycle frame carries a fresh slot-0 word.
          if (fc_reg == 2'd3) begin
            if (match) begin
              if (mcnt_reg == MATCH_LAST) state_next = S_LOCKED;
              else mcnt_next = mcnt_reg + MW'(1);
            end else begin
              mcnt_next  = '0;
              tmr_next   = '0;
              cand_next  = cand_reg + 2'd1;
              att_next   = att_reg + AW'(1);
              state_next = (att_reg == ATT_LAST) ? S_FAIL : S_APPLY;
            end
          end
        end
        S_LOCKED: begin
          if (bus.relock) begin
            state_next = S_APPLY;
            tmr_next   = '0;
            mcnt_next  = '0;
            att_next   = '0;
          end
        end
        S_FAIL: ;
        default: state_next = S_IDLE;
      endcase
    end
    if (state_next == S_IDLE) begin
      tmr_next  = '0;
      fc_next   = '0;
      mcnt_next = '0;
      cand_next = '0;
      att_next  = '0;
    end
  end

  // Registered outputs are computed from the state being entered so they change with it.
  always_comb begin
    des_rst_next    = 1'b1;
    locked_next     = 1'b0;
    align_fail_next = 1'b0;
    case (state_next)
      S_SETTLE, S_CHECK: des_rst_next = 1'b0;
      S_LOCKED: begin
        des_rst_next = 1'b0;
        locked_next  = 1'b1;
      end
      S_FAIL: align_fail_next = 1'b1;
      default: ;
    endcase
    attempts_next = (att_next > AW'(7)) ? 3'd7 : att_next[2:0];
  end

  assign bus.des_rst      = des_rst_reg;
  assign bus.des_phi_init = cand_reg;
  assign bus.locked       = locked_reg;
  assign bus.align_fail   = align_fail_reg;
  assign bus.attempts     = attempts_reg;

endmodule

// File: tb/tb_des_phase_align_ctrl.sv
// Bench for des_phase_align_ctrl: attempt-timeline reference model checked every cycle,
// directed latency pins from the test plan, then randomized enable/relock/noise episodes.
module tb_des_phase_align_ctrl;

  localparam int W  = 9;
  localparam int R  = 2;
  localparam int S  = 16;
  localparam int MN = 8;
  localparam int MS = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_LOCK = 2;
  localparam int M_FAIL = 3;

  typedef struct {
    int mode;
    int age;    // cycles since the current attempt started
    int cand;
    int fails;
    int hits;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  des_phase_align_if #(.W(W)) bus ();

  des_phase_align_ctrl #(
    .W(W), .RST_CYC(R), .SETTLE_CYC(S), .MATCH_N(MN), .MAX_SWEEPS(MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  bit     chk_on = 0;
  int     good_phase = 4;
  bit     noise = 0;
  bit     inject_arm = 0;
  bit     inj_seen = 0;
  bit     inj_done = 0;
  model_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.mode = M_IDLE; r.age = 0; r.cand = 0; r.fails = 0; r.hits = 0;
    return r;
  endfunction

  function automatic model_t step(model_t c, logic en, logic rl, logic [W-1:0] pr, logic [W-1:0] tp);
    model_t n;
    n = c;
    if (c.mode != M_IDLE && en !== 1'b1) begin
      n = model_reset();
    end else begin
      case (c.mode)
        M_IDLE: if (en === 1'b1) begin n.mode = M_RUN; n.age = 0; n.hits = 0; end
        M_RUN: begin
          if (c.age >= R + S && (c.age - R - S) % 4 == 3) begin
            if (pr === tp) begin
              n.hits = c.hits + 1;
              n.age  = c.age + 1;
              if (n.hits == MN) n.mode = M_LOCK;
            end else begin
              n.hits  = 0;
              n.age   = 0;
              n.cand  = (c.cand + 1) % 4;
              n.fails = c.fails + 1;
              if (n.fails == 4 * MS) n.mode = M_FAIL;
            end
          end else begin
            n.age = c.age + 1;
          end
        end
        M_LOCK: if (rl === 1'b1) begin n.mode = M_RUN; n.age = 0; n.hits = 0; n.fails = 0; end
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else m <= step(m, bus.enable, bus.relock, bus.probe, bus.train_pattern);
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("des_rst", 32'(bus.des_rst),
            32'(m.mode == M_IDLE || m.mode == M_FAIL || (m.mode == M_RUN && m.age < R)));
      check("des_phi_init", 32'(bus.des_phi_init), 32'(m.cand));
      check("locked", 32'(bus.locked), 32'(m.mode == M_LOCK));
      check("align_fail", 32'(bus.align_fail), 32'(m.mode == M_FAIL));
      check("attempts", 32'(bus.attempts), 32'((m.fails > 7) ? 7 : m.fails));
    end
  end

  // Stand-in deserializer: the training word appears on slot 0 only at the correct phase.
  always @(negedge clk) begin
    logic [W-1:0] flip;
    bit           bad;
    if ($urandom_range(0, 1) == 1) flip = W'(1) << $urandom_range(0, W - 1);
    else flip = W'($urandom_range(1, (1 << W) - 1));
    bad = (good_phase > 3) || (m.cand != good_phase) || (m.mode != M_RUN);
    if (noise && $urandom_range(0, 15) == 0) bad = 1;
    if (inject_arm && !inj_done && m.mode == M_RUN && m.cand == good_phase && m.hits == 5) begin
      bad = 1;
      inj_seen = 1;
    end
    if (inj_seen && m.cand != good_phase) inj_done = 1;
    bus.probe = bad ? (bus.train_pattern ^ flip) : bus.train_pattern;
  end

  task automatic measure(input bit want_fail, input int limit, output int n);
    bit found;
    n = 0;
    found = 0;
    while (!found && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      found = want_fail ? (bus.align_fail === 1'b1) : (bus.locked === 1'b1);
    end
  endtask

  task automatic start_run(input int good);
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    good_phase = good;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int len;
    bus.enable = 1'b0;
    bus.relock = 1'b0;
    bus.train_pattern = W'($urandom);
    bus.probe = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_des_rst", 32'(bus.des_rst), 32'd1);
    check("rst_phi", 32'(bus.des_phi_init), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_align_fail", 32'(bus.align_fail), 32'd0);
    check("rst_attempts", 32'(bus.attempts), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1;

    // first-try lock at phase 0; des_rst high for the first two APPLY cycles
    start_run(0);
    check("t1_apply_des_rst", 32'(bus.des_rst), 32'd1);
    check("t1_apply_phi", 32'(bus.des_phi_init), 32'd0);
    measure(0, 200, lat);
    check("t1_lock_latency", 32'(lat), 32'd50);
    check("t1_attempts", 32'(bus.attempts), 32'd0);

    // correct phase 2
    start_run(2);
    measure(0, 300, lat);
    check("t2_lock_latency", 32'(lat), 32'd94);
    check("t2_phi", 32'(bus.des_phi_init), 32'd2);
    check("t2_attempts", 32'(bus.attempts), 32'd2);

    // pattern never present
    start_run(4);
    measure(1, 400, lat);
    check("t3_fail_latency", 32'(lat), 32'd176);
    check("t3_des_rst", 32'(bus.des_rst), 32'd1);
    check("t3_locked", 32'(bus.locked), 32'd0);
    check("t3_attempts", 32'(bus.attempts), 32'd7);
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    check("t3_fail_cleared", 32'(bus.align_fail), 32'd0);

    // one bad frame after 5 matches at the correct phase
    inject_arm = 1;
    start_run(1);
    measure(0, 400, lat);
    check("t4_lock_latency", 32'(lat), 32'd180);
    check("t4_attempts", 32'(bus.attempts), 32'd5);
    inject_arm = 0;

    // relock from LOCKED keeps the phase
    @(negedge clk);
    bus.relock = 1'b1;
    @(posedge clk);
    #1;
    bus.relock = 1'b0;
    check("t5_relock_locked", 32'(bus.locked), 32'd0);
    check("t5_relock_phi", 32'(bus.des_phi_init), 32'd1);
    check("t5_relock_des_rst", 32'(bus.des_rst), 32'd1);
    measure(0, 200, lat);
    check("t5_relock_latency", 32'(lat), 32'd50);
    @(negedge clk);
    bus.relock = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    bus.relock = 1'b0;
    check("t5_override_locked", 32'(bus.locked), 32'd0);
    check("t5_override_phi", 32'(bus.des_phi_init), 32'd0);
    check("t5_override_des_rst", 32'(bus.des_rst), 32'd1);

    // asynchronous reset in the SETTLE of the third attempt
    start_run(3);
    repeat (52) @(posedge clk);
    @(negedge clk);
    check("t6_pre_phi", 32'(bus.des_phi_init), 32'd2);
    check("t6_pre_des_rst", 32'(bus.des_rst), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_des_rst", 32'(bus.des_rst), 32'd1);
    check("t6_rst_phi", 32'(bus.des_phi_init), 32'd0);
    check("t6_rst_locked", 32'(bus.locked), 32'd0);
    check("t6_rst_attempts", 32'(bus.attempts), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    measure(0, 300, lat);
    check("t6_restart_latency", 32'(lat), 32'd116);
    check("t6_restart_phi", 32'(bus.des_phi_init), 32'd3);
    check("t6_restart_attempts", 32'(bus.attempts), 32'd3);

    // randomized episodes: noisy training, random relock pulses and enable drops
    for (int ep = 0; ep < 30; ep++) begin
      @(negedge clk);
      bus.enable = 1'b0;
      bus.relock = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      good_phase = $urandom_range(0, 4);
      noise = ($urandom_range(0, 1) == 1);
      bus.train_pattern = W'($urandom);
      bus.enable = 1'b1;
      len = $urandom_range(40, 300);
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        bus.relock = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 249) == 0) bus.enable = 1'b0;
        else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
      end
    end
    @(negedge clk);
    bus.relock = 1'b0;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
